// File: rtl/memory.sv
// memory: small synchronous simple-dual-port RAM used as local scratch storage.
// It has one write port and one read port, both clocked on a single clock.
//
// Ports:
//   clock    - system clock; all state changes on the rising edge
//   reset    - synchronous, active-high; clears every word and dataout
//   write    - write enable; mem[addr_w] <= datain
//   read     - read enable; dataout <= mem[addr_r], otherwise dataout holds
//   addr_w   - write address
//   addr_r   - read address
//   datain   - write data
//   dataout  - registered read data (1-cycle latency)
//
// If a read and a write hit the same address in one cycle, the read sees the
// new data (write-first).
module memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  bypass;

  // The write lands at this same edge, so a same-address read must take the
  // incoming data rather than the stale array contents.
  assign bypass = write && (addr_w == addr_r);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dataout <= '0;
    end else begin
      if (write) begin
        mem[addr_w] <= datain;
      end
      if (read) begin
        dataout <= bypass ? datain : mem[addr_r];
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
module tb_memory;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [2:0] aw;
    logic [2:0] ar;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset, write, read;
  logic [2:0] addr_w, addr_r;
  logic [7:0] datain, dataout;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  logic [7:0] ref_mem [8];
  logic [7:0] ref_out;

  memory dut (
    .clock  (clock),
    .reset  (reset),
    .write  (write),
    .read   (read),
    .addr_w (addr_w),
    .addr_r (addr_r),
    .datain (datain),
    .dataout(dataout)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic rst, logic wr, logic rd, logic [2:0] aw,
                              logic [2:0] ar, logic [7:0] din, logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.aw = aw; v.ar = ar;
    v.din = din; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dataout=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample shortly after the edge.
  task automatic cycle(input logic rst, input logic wr, input logic rd,
                       input logic [2:0] aw, input logic [2:0] ar, input logic [7:0] din);
    reset = rst; write = wr; read = rd; addr_w = aw; addr_r = ar; datain = din;
    @(posedge clock);
    #1;
  endtask

  // Reference: the stated rules applied to a plain array.
  task automatic model_step(input logic rst, input logic wr, input logic rd,
                            input logic [2:0] aw, input logic [2:0] ar, input logic [7:0] din);
    if (rst) begin
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      ref_out = 8'h00;
    end else begin
      if (rd) ref_out = (wr && aw == ar) ? din : ref_mem[ar];
      if (wr) ref_mem[aw] = din;
    end
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; read = 1'b0;
    addr_w = '0; addr_r = '0; datain = '0;

    // Scenario 1: reset, then every address reads zero.
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00));
    for (int a = 0; a < 8; a++) vecs.push_back(mk(0, 0, 1, 0, 3'(a), 8'h00, 8'h00));
    // Scenario 2: writes (dataout holds 0), then reads.
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 5, 0, 8'h05, 8'h00));
    vecs.push_back(mk(0, 1, 0, 7, 0, 8'h04, 8'h00));
    vecs.push_back(mk(0, 1, 0, 4, 0, 8'h10, 8'h00));
    vecs.push_back(mk(0, 1, 0, 3, 0, 8'h40, 8'h00));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h70, 8'h00));
    vecs.push_back(mk(0, 1, 0, 2, 0, 8'h04, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 5, 8'h00, 8'h05));
    vecs.push_back(mk(0, 0, 1, 0, 2, 8'h00, 8'h04));
    vecs.push_back(mk(0, 0, 1, 0, 4, 8'h00, 8'h10));
    vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h70));
    vecs.push_back(mk(0, 0, 1, 0, 3, 8'h00, 8'h40));
    vecs.push_back(mk(0, 0, 1, 0, 7, 8'h00, 8'h04));
    // Scenario 6: reset with write=1; write discarded, everything reads 0.
    vecs.push_back(mk(1, 1, 0, 6, 0, 8'hAA, 8'h00));
    for (int a = 0; a < 8; a++) vecs.push_back(mk(0, 0, 1, 0, 3'(a), 8'h00, 8'h00));
    // Scenario 3: write-first bypass on address 5.
    vecs.push_back(mk(0, 1, 0, 5, 0, 8'h05, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 5, 8'h00, 8'h05));
    vecs.push_back(mk(0, 1, 1, 5, 5, 8'h08, 8'h08));
    vecs.push_back(mk(0, 0, 1, 0, 5, 8'h00, 8'h08));
    // Scenario 4: concurrent write to 4 while reading 0.
    vecs.push_back(mk(0, 1, 1, 4, 0, 8'h10, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 4, 8'h00, 8'h10));
    // Scenario 5: read=0 for 3 cycles while writes occur -> dataout holds.
    vecs.push_back(mk(0, 1, 0, 4, 4, 8'h33, 8'h10));
    vecs.push_back(mk(0, 1, 0, 5, 4, 8'h44, 8'h10));
    vecs.push_back(mk(0, 1, 0, 0, 4, 8'h55, 8'h10));
    vecs.push_back(mk(0, 0, 1, 0, 4, 8'h00, 8'h33));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h55));

    @(negedge clock);
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].aw, vecs[i].ar, vecs[i].din);
      check($sformatf("vec%0d", i), dataout, vecs[i].exp);
    end

    // Hand sequence: reset beats a same-address read+write in the same cycle.
    cycle(0, 1, 0, 2, 0, 8'hC3);
    cycle(0, 0, 1, 0, 2, 8'h00);
    check("pre_rst_read", dataout, 8'hC3);
    cycle(1, 1, 1, 2, 2, 8'hFF);
    check("rst_priority", dataout, 8'h00);
    cycle(0, 0, 1, 0, 2, 8'h00);
    check("rst_cleared_w", dataout, 8'h00);
    // Back-to-back write-first on the same address.
    cycle(0, 1, 1, 6, 6, 8'h11);
    check("wf_back1", dataout, 8'h11);
    cycle(0, 1, 1, 6, 6, 8'h22);
    check("wf_back2", dataout, 8'h22);
    cycle(0, 0, 1, 0, 6, 8'h00);
    check("wf_back_rd", dataout, 8'h22);

    // Randomized traffic against the reference model.
    cycle(1, 0, 0, 0, 0, 8'h00);
    model_step(1, 0, 0, 0, 0, 8'h00);
    check("rand_reset", dataout, ref_out);
    for (int n = 0; n < 400; n++) begin
      logic       r_rst, r_wr, r_rd;
      logic [2:0] r_aw, r_ar;
      logic [7:0] r_din;
      r_rst = ($urandom_range(0, 39) == 0);
      r_wr  = $urandom_range(0, 1) == 1;
      r_rd  = $urandom_range(0, 3) != 0;
      r_aw  = 3'($urandom_range(0, 7));
      r_ar  = ($urandom_range(0, 3) == 0) ? r_aw : 3'($urandom_range(0, 7));
      r_din = 8'($urandom);
      cycle(r_rst, r_wr, r_rd, r_aw, r_ar, r_din);
      model_step(r_rst, r_wr, r_rd, r_aw, r_ar, r_din);
      check($sformatf("rand%0d", n), dataout, ref_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
